// File: rtl/rect_fill_pkg.sv
// rect_fill_pkg -- shared types and constants for the rectangle-fill engine.
//   fill_state_t : control FSM states (IDLE, FILL, DONE)
//   fill_mode_t  : per-pixel colour source (SOLID, XSTRIPE, YSTRIPE, RSVD)
//   DEF_SCREEN_W / DEF_SCREEN_H : default visible screen size, shared with
//                                 the top level so both agree on the frame.
package rect_fill_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fill_state_t;

  typedef enum logic [1:0] {
    MODE_SOLID   = 2'd0,
    MODE_XSTRIPE = 2'd1,
    MODE_YSTRIPE = 2'd2,
    MODE_RSVD    = 2'd3   // decoded exactly like MODE_SOLID
  } fill_mode_t;

  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;

endpackage : rect_fill_pkg

// File: rtl/rect_fill_raster_scan.sv
// raster_scan -- x/y scan counter pair for rect_fill.
//   clk, rst_n      : clock, synchronous active-low reset
//   load            : capture origin/size and present (x_start, y_start)
//   step            : advance one pixel in raster order
//   x_start/y_start : rectangle origin
//   w / h           : rectangle size, must be non-zero when load is high
//   x / y           : current pixel (registered)
//   x_next / y_next : value x / y will take at the next edge
//   last            : current pixel is the final one of the rectangle
// Position inside the rectangle is tracked with separate column/row
// counters, so the end-of-row compare never depends on coordinate wrap.
module raster_scan #(
  parameter int X_W = 8,
  parameter int Y_W = 7
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           step,
  input  logic [X_W-1:0] x_start,
  input  logic [Y_W-1:0] y_start,
  input  logic [X_W:0]   w,
  input  logic [Y_W:0]   h,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [X_W-1:0] x_next,
  output logic [Y_W-1:0] y_next,
  output logic           last
);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [X_W-1:0] x_org_q, x_org_d;
  logic [X_W:0]   col_q, col_d;
  logic [Y_W:0]   row_q, row_d;
  logic [X_W:0]   col_max_q, col_max_d;
  logic [Y_W:0]   row_max_q, row_max_d;
  logic           row_end;

  assign row_end = (col_q == col_max_q);
  assign last    = row_end && (row_q == row_max_q);

  // NOTE: every always_comb output gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    x_org_d   = x_org_q;
    col_d     = col_q;
    row_d     = row_q;
    col_max_d = col_max_q;
    row_max_d = row_max_q;
    if (load) begin
      x_d       = x_start;
      y_d       = y_start;
      x_org_d   = x_start;
      col_d     = '0;
      row_d     = '0;
      col_max_d = w - 1'b1;
      row_max_d = h - 1'b1;
    end else if (step) begin
      if (row_end) begin
        col_d = '0;
        x_d   = x_org_q;
        row_d = row_q + 1'b1;
        y_d   = y_q + 1'b1;   // wraps modulo 2^Y_W when unclipped
      end else begin
        col_d = col_q + 1'b1;
        x_d   = x_q + 1'b1;   // wraps modulo 2^X_W when unclipped
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is
  // synchronous, sampled on the clock edge like any other input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q       <= '0;
      y_q       <= '0;
      x_org_q   <= '0;
      col_q     <= '0;
      row_q     <= '0;
      col_max_q <= '0;
      row_max_q <= '0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      x_org_q   <= x_org_d;
      col_q     <= col_d;
      row_q     <= row_d;
      col_max_q <= col_max_d;
      row_max_q <= row_max_d;
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign x_next = x_d;
  assign y_next = y_d;

endmodule : raster_scan

// File: rtl/rect_fill.sv
// rect_fill -- rectangle-fill engine driving the VGA adapter pixel port.
// Draws a w x h rectangle at (x0, y0), one pixel per clock, in SOLID,
// XSTRIPE (colour = x) or YSTRIPE (colour = y) mode, using a level
// start/done handshake.
//   clk, rst_n           : clock, synchronous active-low reset
//   start                : level request, held until done is seen
//   x0, y0, w, h         : origin and size (latched on start; 0 size allowed)
//   colour, mode         : solid colour and colour mode (latched on start)
//   done                 : fill complete, held while start stays high
//   vga_x, vga_y         : pixel coordinate
//   vga_colour, vga_plot : pixel colour and pixel-valid strobe
// All outputs are registered.
// Build option: define RECT_FILL_CLIP_EN to clamp the rectangle to the
// visible screen at latch time; undefined, coordinates wrap and exactly
// w*h pixels are emitted.
module rect_fill
  import rect_fill_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [X_W-1:0]      x0,
  input  logic [Y_W-1:0]      y0,
  input  logic [X_W:0]        w,
  input  logic [Y_W:0]        h,
  input  logic [COLOUR_W-1:0] colour,
  input  logic [1:0]          mode,
  output logic                done,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot
);

`ifdef RECT_FILL_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  localparam logic [X_W:0] SCR_W = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] SCR_H = (Y_W+1)'(SCREEN_H);

  fill_state_t         state_q, state_d;
  fill_mode_t          mode_q, mode_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic [COLOUR_W-1:0] pix_colour_q, pix_colour_d;
  logic                done_q, done_d;
  logic                plot_q, plot_d;

  logic [X_W:0]        x0_ext, room_x, w_clip, w_eff;
  logic [Y_W:0]        y0_ext, room_y, h_clip, h_eff;
  logic                zero_size;

  logic                load, step, last;
  logic [X_W-1:0]      scan_x, scan_x_next;
  logic [Y_W-1:0]      scan_y, scan_y_next;

  // Effective size. Room to the screen edge is computed one bit wider than
  // the coordinate so the compare sees the untruncated end position.
  always_comb begin
    x0_ext = {1'b0, x0};
    y0_ext = {1'b0, y0};
    room_x = (x0_ext >= SCR_W) ? '0 : SCR_W - x0_ext;
    room_y = (y0_ext >= SCR_H) ? '0 : SCR_H - y0_ext;
    w_clip = (w < room_x) ? w : room_x;
    h_clip = (h < room_y) ? h : room_y;
    w_eff  = CLIP_EN ? w_clip : w;
    h_eff  = CLIP_EN ? h_clip : h;
  end

  assign zero_size = (w_eff == '0) || (h_eff == '0);

  raster_scan #(
    .X_W (X_W),
    .Y_W (Y_W)
  ) u_scan (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .step    (step),
    .x_start (x0),
    .y_start (y0),
    .w       (w_eff),
    .h       (h_eff),
    .x       (scan_x),
    .y       (scan_y),
    .x_next  (scan_x_next),
    .y_next  (scan_y_next),
    .last    (last)
  );

  // Control FSM: next state, scan control and parameter latch.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    colour_d = colour_q;
    load     = 1'b0;
    step     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d   = fill_mode_t'(mode);
          colour_d = colour;
          if (zero_size) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_FILL;
            load    = 1'b1;
          end
        end
      end
      ST_FILL: begin
        // Hold the scanner on the final pixel rather than stepping past it.
        if (last) state_d = ST_DONE;
        else      step    = 1'b1;
      end
      ST_DONE: begin
        if (!start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output registers are computed from the next state and the scanner's
  // next coordinate so the pixel, its colour and the strobe line up.
  always_comb begin
    done_d = (state_d == ST_DONE);
    plot_d = (state_d == ST_FILL);
    unique case (mode_d)
      MODE_XSTRIPE: pix_colour_d = COLOUR_W'(scan_x_next);
      MODE_YSTRIPE: pix_colour_d = COLOUR_W'(scan_y_next);
      default:      pix_colour_d = colour_d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_SOLID;
      colour_q     <= '0;
      pix_colour_q <= '0;
      done_q       <= 1'b0;
      plot_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      colour_q     <= colour_d;
      pix_colour_q <= pix_colour_d;
      done_q       <= done_d;
      plot_q       <= plot_d;
    end
  end

  assign done       = done_q;
  assign vga_plot   = plot_q;
  assign vga_colour = pix_colour_q;
  assign vga_x      = scan_x;
  assign vga_y      = scan_y;

endmodule : rect_fill

// File: tb/tb_rect_fill.sv
// tb_rect_fill -- scoreboard bench for rect_fill. Stimulus pushes the
// expected pixel stream into a queue; a monitor pops and compares on every
// vga_plot cycle. Latency and handshake are checked by the stimulus thread.
module tb_rect_fill;
  import rect_fill_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] x0 = '0;
  logic [6:0] y0 = '0;
  logic [8:0] w = '0;
  logic [7:0] h = '0;
  logic [2:0] colour = '0;
  logic [1:0] mode = '0;
  logic       done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   plot_cnt = 0;

  rect_fill dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .x0         (x0),
    .y0         (y0),
    .w          (w),
    .h          (h),
    .colour     (colour),
    .mode       (mode),
    .done       (done),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every plotted pixel must match the head of the scoreboard.
  initial begin
    pix_t e;
    forever begin
      @(negedge clk);
      if (vga_plot === 1'b1) begin
        plot_cnt++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_plot: got (%0d,%0d,c%0d) expected no pixel",
                   vga_x, vga_y, vga_colour);
        end else begin
          e = sb.pop_front();
          if ({vga_x, vga_y, vga_colour} !== e) begin
            errors++;
            $display("FAIL pixel: got (%0d,%0d,c%0d) expected (%0d,%0d,c%0d)",
                     vga_x, vga_y, vga_colour, e.x, e.y, e.c);
          end
        end
      end
    end
  end

  // Reference pixel stream for one rectangle.
  task automatic push_rect(input int ax0, input int ay0, input int weff,
                           input int heff, input int acol, input int amode);
    pix_t p;
    for (int j = 0; j < heff; j++) begin
      for (int i = 0; i < weff; i++) begin
        p.x = 8'((ax0 + i) % 256);
        p.y = 7'((ay0 + j) % 128);
        case (amode)
          1:       p.c = 3'(p.x);
          2:       p.c = 3'(p.y);
          default: p.c = 3'(acol);
        endcase
        sb.push_back(p);
      end
    end
  endtask

  // Issue one fill and check done latency, plot count and the handshake.
  // pulse=1 drops start one cycle after it is sampled.
  task automatic run_fill(input string name, input int ax0, input int ay0,
                          input int aw, input int ah, input int acol,
                          input int amode, input bit pulse);
    int weff, heff, n, k, base;
    weff = aw;
    heff = ah;
`ifdef RECT_FILL_CLIP_EN
    weff = (ax0 >= 160) ? 0 : ((aw < 160 - ax0) ? aw : 160 - ax0);
    heff = (ay0 >= 120) ? 0 : ((ah < 120 - ay0) ? ah : 120 - ay0);
`endif
    n = weff * heff;
    push_rect(ax0, ay0, weff, heff, acol, amode);
    @(negedge clk);
    base   = plot_cnt;
    x0     = 8'(ax0);
    y0     = 7'(ay0);
    w      = 9'(aw);
    h      = 8'(ah);
    colour = 3'(acol);
    mode   = 2'(amode);
    start  = 1'b1;
    @(posedge clk);                       // E0
    k = 0;
    while (k < 20000) begin
      @(negedge clk);
      k++;
      if (pulse && k == 1) start = 1'b0;
      if (done === 1'b1) break;
    end
    check({name, "_done_cycle"}, k, n + 1);
    check({name, "_plots"}, plot_cnt - base, n);
    check({name, "_queue_left"}, sb.size(), 0);
    if (!pulse) begin
      repeat (2) begin
        @(negedge clk);
        check({name, "_done_held"}, int'(done), 1);
      end
      start = 1'b0;
    end
    @(negedge clk);
    check({name, "_done_drop"}, int'(done), 0);
    check({name, "_idle"}, int'(dut.state_q), int'(ST_IDLE));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_done", int'(done), 0);
    check("rst_plot", int'(vga_plot), 0);
    check("rst_x", int'(vga_x), 0);
    check("rst_y", int'(vga_y), 0);
    check("rst_colour", int'(vga_colour), 0);
    rst_n = 1'b1;

    run_fill("solid",    10,   5,   3,   2, 5, 0, 1'b0);
    run_fill("zero_w",   20,  20,   0,   4, 1, 0, 1'b0);
    run_fill("zero_h",   20,  20,   7,   0, 1, 1, 1'b0);
    run_fill("rsvd",      0,   0,   2,   2, 6, 3, 1'b0);
    run_fill("ystripe",  30,  40,   2,   9, 0, 2, 1'b1);
    run_fill("corner",  158, 118,   5,   5, 2, 1, 1'b0);
    run_fill("offx",    170,  10,   2,   2, 4, 0, 1'b0);
    run_fill("wrap",    250, 126,  10,   3, 7, 1, 1'b0);
    run_fill("full",      0,   0, 160, 120, 0, 1, 1'b0);

    // Reset while filling: after 50 pixels, assert rst_n for one edge.
    push_rect(10, 5, 20, 3, 3, 0);        // first 50 of a 20x10 fill
    while (sb.size() > 50) void'(sb.pop_back());
    @(negedge clk);
    x0 = 8'd10; y0 = 7'd5; w = 9'd20; h = 8'd10; colour = 3'd3; mode = 2'd0;
    start = 1'b1;
    @(posedge clk);
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("midrst_plot", int'(vga_plot), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_x", int'(vga_x), 0);
    check("midrst_y", int'(vga_y), 0);
    check("midrst_colour", int'(vga_colour), 0);
    check("midrst_idle", int'(dut.state_q), int'(ST_IDLE));
    check("midrst_queue_left", sb.size(), 0);
    rst_n = 1'b1;
    run_fill("restart", 10, 5, 3, 1, 3, 0, 1'b0);

    repeat (2) @(negedge clk);
    check("tail_queue_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_rect_fill
